i2c_csr_bank: RTL and testbench

Parametrised second-generation control/status block for the I2C master. Decodes a single-outstanding valid/ready register bus into CONTROL, PRESCALE, TX/RX data, STATUS, PARAM and new interrupt registers. Owns TX and RX FIFOs of configurable depth between software and the bit engine. Adds byte-level command bits, overflow/underflow detection and a maskable W1C interrupt, none of which the first generation has.

---
 rtl/i2c_pkg.sv | 59 +++++
 rtl/i2c_sync_fifo.sv | 51 +++++
 rtl/i2c_csr_bank.sv | 264 ++++++++++++++++++++++++++
 tb/tb_i2c_csr_bank.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared register layout, address map and reset values for the I2C CSR bank.
package i2c_pkg;

  // Word addresses of the register map
  localparam int unsigned I2C_CONTROL_REG_POS  = 0;
  localparam int unsigned I2C_PRESCALE_REG_POS = 1;
  localparam int unsigned I2C_TX_DATA_REG_POS  = 2;
  localparam int unsigned I2C_RX_DATA_REG_POS  = 3;
  localparam int unsigned I2C_STATUS_REG_POS   = 4;
  localparam int unsigned I2C_PARAM_REG_POS    = 5;
  localparam int unsigned I2C_IRQ_EN_REG_POS   = 6;
  localparam int unsigned I2C_IRQ_STAT_REG_POS = 7;
  localparam int unsigned I2C_CMD_REG_POS      = 8;
  localparam int unsigned I2C_REG_NUM          = 9;

  // Interrupt bit positions within IRQ_EN / IRQ_STAT
  localparam int unsigned I2C_IRQ_W        = 5;
  localparam int unsigned I2C_IRQ_TX_EMPTY = 0;
  localparam int unsigned I2C_IRQ_RX_AVAIL = 1;
  localparam int unsigned I2C_IRQ_NACK     = 2;
  localparam int unsigned I2C_IRQ_TX_OVF   = 3;
  localparam int unsigned I2C_IRQ_RX_ERR   = 4;

  typedef logic [I2C_IRQ_W-1:0] i2c_irq_t;

  typedef struct packed {
    logic core_en;
    logic core_rst;
  } i2c_control_t;

  // Byte-level command attached to the next TX_DATA write
  typedef struct packed {
    logic stop;
    logic start;
    logic read;
  } i2c_cmd_t;

  typedef struct packed {
    logic [7:0] rsvd_hi;
    logic [7:0] tx_level;
    logic [7:0] rx_level;
    logic [1:0] rsvd_lo;
    logic       rx_empty;
    logic       tx_empty;
    logic       rx_full;
    logic       tx_full;
    logic       rx_ack;
    logic       busy;
  } i2c_status_t;

  // Bit engine held in soft reset until software releases it
  localparam i2c_control_t I2C_REG_INIT = '{core_en: 1'b0, core_rst: 1'b1};

  // Levels are reported in 8 bits; a 256-deep full FIFO reads as 255
  function automatic logic [7:0] i2c_sat_level(input logic [15:0] lvl);
    return (lvl > 16'd255) ? 8'hFF : lvl[7:0];
  endfunction

endpackage

// File: rtl/i2c_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers and a synchronous flush.
module i2c_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     arstn_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  // A pop frees the slot a simultaneous push needs, so full + push + pop is legal
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = mem_q[rptr_q[AW-1:0]];
  assign level_o = wptr_q - rptr_q;

  // Pointer update; flush empties the FIFO without touching storage
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage write, no reset needed since contents are only read when non-empty
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/i2c_csr_bank.sv
// Register bank for the I2C master: bus decode, TX/RX FIFOs and interrupt logic.
module i2c_csr_bank
  import i2c_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned PRESCALE_W = 16,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ADDR_W     = 4,
  parameter logic [7:0]  VERSION    = 8'h02
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_W-1:0]     req_addr_i,
  input  logic                  req_write_i,
  input  logic [31:0]           req_wdata_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [31:0]           resp_rdata_o,
  output logic                  resp_err_o,
  output logic                  core_rst_o,
  output logic                  core_en_o,
  output logic [PRESCALE_W-1:0] prescale_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  output logic [DATA_W+2:0]     tx_data_o,
  input  logic                  rx_valid_i,
  input  logic [DATA_W-1:0]     rx_data_i,
  input  logic                  byte_done_i,
  input  logic                  rx_ack_i,
  input  logic                  busy_i,
  output logic                  irq_o
);

  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned TX_W  = DATA_W + 3;
  localparam logic [31:0] PARAM_WORD = {VERSION, 8'(FIFO_DEPTH), 8'(I2C_REG_NUM), 8'(DATA_W)};

  typedef enum logic [0:0] {StIdle, StResp} bus_state_e;

  bus_state_e            state_q;
  logic                  req_ready_q, resp_valid_q, resp_err_q;
  logic [31:0]           resp_rdata_q;
  i2c_control_t          control_q;
  logic [PRESCALE_W-1:0] prescale_q;
  i2c_irq_t              irq_en_q, irq_stat_q, irq_stat_d, irq_set;
  i2c_cmd_t              cmd_q;
  logic                  tx_empty_q, irq_q;

  logic             tx_push, tx_pop, tx_full, tx_empty;
  logic [TX_W-1:0]  tx_wdata, tx_rdata;
  logic [LVL_W-1:0] tx_level;
  logic             rx_pop, rx_full, rx_empty, rx_push_ok;
  logic [DATA_W-1:0] rx_rdata;
  logic [LVL_W-1:0] rx_level;

  logic        accept;
  logic [31:0] addr_ext;
  logic [31:0] rd_data;
  logic        rd_err, wr_ctrl, wr_pre, wr_irq_en, wr_irq_stat, wr_cmd, tx_ovf, rx_udf, rx_ovf;
  i2c_status_t status;
  logic        unused_wdata;

  assign unused_wdata = ^req_wdata_i;
  assign accept       = req_valid_i & req_ready_q;
  assign addr_ext     = 32'(req_addr_i);

  i2c_sync_fifo #(.WIDTH(TX_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .flush_i (control_q.core_rst),
    .push_i  (tx_push),
    .wdata_i (tx_wdata),
    .pop_i   (tx_pop),
    .rdata_o (tx_rdata),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .level_o (tx_level)
  );

  i2c_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .flush_i (control_q.core_rst),
    .push_i  (rx_valid_i),
    .wdata_i (rx_data_i),
    .pop_i   (rx_pop),
    .rdata_o (rx_rdata),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .level_o (rx_level)
  );

  assign tx_valid_o = ~tx_empty;
  assign tx_data_o  = tx_rdata;
  assign tx_pop     = ~tx_empty & tx_ready_i;
  assign tx_wdata   = {cmd_q, req_wdata_i[DATA_W-1:0]};

  // Live status word
  always_comb begin
    status          = '0;
    status.tx_level = i2c_sat_level(16'(tx_level));
    status.rx_level = i2c_sat_level(16'(rx_level));
    status.rx_empty = rx_empty;
    status.tx_empty = tx_empty;
    status.rx_full  = rx_full;
    status.tx_full  = tx_full;
    status.rx_ack   = rx_ack_i;
    status.busy     = busy_i;
  end

  // Decode the accepted request into side effects and read data
  always_comb begin
    rd_data     = '0;
    rd_err      = 1'b0;
    wr_ctrl     = 1'b0;
    wr_pre      = 1'b0;
    wr_irq_en   = 1'b0;
    wr_irq_stat = 1'b0;
    wr_cmd      = 1'b0;
    tx_push     = 1'b0;
    rx_pop      = 1'b0;
    tx_ovf      = 1'b0;
    rx_udf      = 1'b0;
    if (accept) begin
      unique case (addr_ext)
        I2C_CONTROL_REG_POS: begin
          if (req_write_i) wr_ctrl = 1'b1;
          else             rd_data = 32'(control_q);
        end
        I2C_PRESCALE_REG_POS: begin
          if (req_write_i) wr_pre  = 1'b1;
          else             rd_data = 32'(prescale_q);
        end
        I2C_TX_DATA_REG_POS: begin
          // Write-only; a concurrent engine pop makes room in a full FIFO
          if (req_write_i) begin
            if (tx_full && !tx_pop) begin
              rd_err = 1'b1;
              tx_ovf = 1'b1;
            end else begin
              tx_push = 1'b1;
            end
          end
        end
        I2C_RX_DATA_REG_POS: begin
          if (req_write_i) begin
            rd_err = 1'b1;
          end else if (rx_empty) begin
            rd_err = 1'b1;
            rx_udf = 1'b1;
          end else begin
            rx_pop  = 1'b1;
            rd_data = 32'(rx_rdata);
          end
        end
        I2C_STATUS_REG_POS: begin
          if (req_write_i) rd_err  = 1'b1;
          else             rd_data = status;
        end
        I2C_PARAM_REG_POS: begin
          if (req_write_i) rd_err  = 1'b1;
          else             rd_data = PARAM_WORD;
        end
        I2C_IRQ_EN_REG_POS: begin
          if (req_write_i) wr_irq_en = 1'b1;
          else             rd_data   = 32'(irq_en_q);
        end
        I2C_IRQ_STAT_REG_POS: begin
          if (req_write_i) wr_irq_stat = 1'b1;
          else             rd_data     = 32'(irq_stat_q);
        end
        I2C_CMD_REG_POS: begin
          if (req_write_i) wr_cmd  = 1'b1;
          else             rd_data = 32'(cmd_q);
        end
        default: rd_err = 1'b1;
      endcase
    end
  end

  // Interrupt set events and W1C; a set in the same cycle as a clear wins
  always_comb begin
    rx_push_ok = rx_valid_i & (~rx_full | rx_pop);
    rx_ovf     = rx_valid_i & rx_full & ~rx_pop;
    irq_set    = '0;
    irq_set[I2C_IRQ_TX_EMPTY] = tx_empty & ~tx_empty_q;
    irq_set[I2C_IRQ_RX_AVAIL] = rx_push_ok;
    irq_set[I2C_IRQ_NACK]     = byte_done_i & rx_ack_i;
    irq_set[I2C_IRQ_TX_OVF]   = tx_ovf;
    irq_set[I2C_IRQ_RX_ERR]   = rx_ovf | rx_udf;
    irq_stat_d = irq_stat_q;
    if (wr_irq_stat) irq_stat_d = irq_stat_q & ~req_wdata_i[I2C_IRQ_W-1:0];
    irq_stat_d = irq_stat_d | irq_set;
    if (control_q.core_rst) irq_stat_d = '0;
  end

  // Software-visible registers and interrupt output
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      control_q  <= I2C_REG_INIT;
      prescale_q <= '0;
      irq_en_q   <= '0;
      irq_stat_q <= '0;
      cmd_q      <= '0;
      tx_empty_q <= 1'b1;
      irq_q      <= 1'b0;
    end else begin
      if (wr_ctrl)   control_q  <= i2c_control_t'(req_wdata_i[1:0]);
      if (wr_pre)    prescale_q <= req_wdata_i[PRESCALE_W-1:0];
      if (wr_irq_en) irq_en_q   <= req_wdata_i[I2C_IRQ_W-1:0];
      // CMD applies to exactly one pushed byte
      if (wr_cmd)       cmd_q <= i2c_cmd_t'(req_wdata_i[2:0]);
      else if (tx_push) cmd_q <= '0;
      irq_stat_q <= irq_stat_d;
      tx_empty_q <= tx_empty;
      irq_q      <= |(irq_stat_q & irq_en_q);
    end
  end

  // Bus handshake FSM: one outstanding request, response held until consumed
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q      <= StIdle;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_q      <= StResp;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= rd_err ? 32'd0 : rd_data;
            resp_err_q   <= rd_err;
          end
        end
        StResp: begin
          if (resp_ready_i) begin
            state_q      <= StIdle;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = resp_err_q;
  assign core_rst_o   = control_q.core_rst;
  assign core_en_o    = control_q.core_en;
  assign prescale_o   = prescale_q;
  assign irq_o        = irq_q;

endmodule

// File: tb/tb_i2c_csr_bank.sv
// Self-checking bench for i2c_csr_bank with default parameters.
module tb_i2c_csr_bank;

  localparam int LIMIT = 50;

  logic        clk_i = 1'b0;
  logic        arstn_i;
  logic        req_valid_i, req_ready_o, req_write_i;
  logic [3:0]  req_addr_i;
  logic [31:0] req_wdata_i;
  logic        resp_valid_o, resp_ready_i, resp_err_o;
  logic [31:0] resp_rdata_o;
  logic        core_rst_o, core_en_o;
  logic [15:0] prescale_o;
  logic        tx_valid_o, tx_ready_i;
  logic [10:0] tx_data_o;
  logic        rx_valid_i;
  logic [7:0]  rx_data_i;
  logic        byte_done_i, rx_ack_i, busy_i, irq_o;

  i2c_csr_bank dut (
    .clk_i        (clk_i),
    .arstn_i      (arstn_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_addr_i   (req_addr_i),
    .req_write_i  (req_write_i),
    .req_wdata_i  (req_wdata_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_rdata_o (resp_rdata_o),
    .resp_err_o   (resp_err_o),
    .core_rst_o   (core_rst_o),
    .core_en_o    (core_en_o),
    .prescale_o   (prescale_o),
    .tx_valid_o   (tx_valid_o),
    .tx_ready_i   (tx_ready_i),
    .tx_data_o    (tx_data_o),
    .rx_valid_i   (rx_valid_i),
    .rx_data_i    (rx_data_i),
    .byte_done_i  (byte_done_i),
    .rx_ack_i     (rx_ack_i),
    .busy_i       (busy_i),
    .irq_o        (irq_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  int    total = 0;
  int    bad   = 0;
  exp_t  exp_q[$];
  string name_q[$];
  vec_t  vecs[22];

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // Present a request and push its expected response; returns 1 time unit after acceptance
  task automatic drive_req(input string name, input logic wr, input logic [3:0] addr,
                           input logic [31:0] wdata, input logic [31:0] erd, input logic eerr);
    int n;
    exp_t e;
    e.rdata = erd;
    e.err   = eerr;
    exp_q.push_back(e);
    name_q.push_back(name);
    req_valid_i = 1'b1;
    req_write_i = wr;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    n = 0;
    @(negedge clk_i);
    while (!req_ready_o && n < LIMIT) begin
      @(negedge clk_i);
      n++;
    end
    if (!req_ready_o) begin
      total++;
      bad++;
      $display("FAIL %s_accept: req_ready got 0 want 1 within %0d cycles", name, LIMIT);
    end
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
  endtask

  // Wait for the response, pop the scoreboard and compare
  task automatic wait_resp(input logic check_lat);
    int    n;
    exp_t  e;
    string nm;
    resp_ready_i = 1'b1;
    n = 0;
    @(negedge clk_i);
    while (!resp_valid_o && n < LIMIT) begin
      @(negedge clk_i);
      n++;
    end
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL sb_underflow: got response with 0 expected entries, want 1");
    end else begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      if (!resp_valid_o) begin
        total++;
        bad++;
        $display("FAIL %s_resp: resp_valid got 0 want 1 within %0d cycles", nm, LIMIT);
      end else begin
        if (check_lat) check({nm, "_lat"}, 32'(n), 32'd0);
        check({nm, "_rdata"}, resp_rdata_o, e.rdata);
        check({nm, "_err"}, 32'(resp_err_o), 32'(e.err));
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic access(input string name, input logic wr, input logic [3:0] addr,
                        input logic [31:0] wdata, input logic [31:0] erd, input logic eerr);
    drive_req(name, wr, addr, wdata, erd, eerr);
    wait_resp(1'b1);
  endtask

  task automatic check_rst(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready_o), 32'd1);
    check({tag, "_resp_valid"}, 32'(resp_valid_o), 32'd0);
    check({tag, "_resp_rdata"}, resp_rdata_o, 32'd0);
    check({tag, "_resp_err"}, 32'(resp_err_o), 32'd0);
    check({tag, "_core_rst"}, 32'(core_rst_o), 32'd1);
    check({tag, "_core_en"}, 32'(core_en_o), 32'd0);
    check({tag, "_prescale"}, 32'(prescale_o), 32'd0);
    check({tag, "_tx_valid"}, 32'(tx_valid_o), 32'd0);
    check({tag, "_irq"}, 32'(irq_o), 32'd0);
  endtask

  initial begin
    // wr, addr, wdata, expected rdata, expected err
    vecs[0]  = '{1'b0, 4'd5,  32'h0,          32'h0210_0908, 1'b0};
    vecs[1]  = '{1'b0, 4'd4,  32'h0,          32'h0000_0030, 1'b0};
    vecs[2]  = '{1'b0, 4'd0,  32'h0,          32'h0000_0001, 1'b0};
    vecs[3]  = '{1'b0, 4'd6,  32'h0,          32'h0,         1'b0};
    vecs[4]  = '{1'b0, 4'd7,  32'h0,          32'h0,         1'b0};
    vecs[5]  = '{1'b0, 4'd8,  32'h0,          32'h0,         1'b0};
    vecs[6]  = '{1'b0, 4'd9,  32'h0,          32'h0,         1'b1};
    vecs[7]  = '{1'b0, 4'd15, 32'h0,          32'h0,         1'b1};
    vecs[8]  = '{1'b1, 4'd4,  32'hFFFF_FFFF,  32'h0,         1'b1};
    vecs[9]  = '{1'b1, 4'd5,  32'hFFFF_FFFF,  32'h0,         1'b1};
    vecs[10] = '{1'b1, 4'd3,  32'hFFFF_FFFF,  32'h0,         1'b1};
    vecs[11] = '{1'b1, 4'd1,  32'hDEAD_1234,  32'h0,         1'b0};
    vecs[12] = '{1'b0, 4'd1,  32'h0,          32'h0000_1234, 1'b0};
    vecs[13] = '{1'b1, 4'd6,  32'hFFFF_FFFF,  32'h0,         1'b0};
    vecs[14] = '{1'b0, 4'd6,  32'h0,          32'h0000_001F, 1'b0};
    vecs[15] = '{1'b1, 4'd6,  32'h0,          32'h0,         1'b0};
    vecs[16] = '{1'b1, 4'd8,  32'h0000_00FF,  32'h0,         1'b0};
    vecs[17] = '{1'b0, 4'd8,  32'h0,          32'h0000_0007, 1'b0};
    vecs[18] = '{1'b1, 4'd8,  32'h0000_0003,  32'h0,         1'b0};
    vecs[19] = '{1'b1, 4'd0,  32'hFFFF_FFFE,  32'h0,         1'b0};
    vecs[20] = '{1'b0, 4'd0,  32'h0,          32'h0000_0002, 1'b0};
    vecs[21] = '{1'b0, 4'd4,  32'h0,          32'h0000_0030, 1'b0};

    arstn_i      = 1'b0;
    req_valid_i  = 1'b0;
    req_write_i  = 1'b0;
    req_addr_i   = '0;
    req_wdata_i  = '0;
    resp_ready_i = 1'b1;
    tx_ready_i   = 1'b0;
    rx_valid_i   = 1'b0;
    rx_data_i    = '0;
    byte_done_i  = 1'b0;
    rx_ack_i     = 1'b0;
    busy_i       = 1'b0;
    tick();
    tick();
    check_rst("rst");
    arstn_i = 1'b1;
    tick();

    // Register map, reset values and error decoding
    for (int i = 0; i < 22; i++) begin
      access($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata,
             vecs[i].rdata, vecs[i].err);
    end
    check("core_en_out", 32'(core_en_o), 32'd1);
    check("core_rst_out", 32'(core_rst_o), 32'd0);
    check("prescale_out", 32'(prescale_o), 32'h1234);

    // CMD is attached to the pushed byte and then cleared
    access("tx_a5", 1'b1, 4'd2, 32'h0000_00A5, 32'h0, 1'b0);
    check("tx_valid_a5", 32'(tx_valid_o), 32'd1);
    check("tx_data_a5", 32'(tx_data_o), 32'h3A5);
    access("cmd_cleared", 1'b0, 4'd8, 32'h0, 32'h0, 1'b0);

    // Flush, then fill TX to full and overflow
    access("ctl_flush", 1'b1, 4'd0, 32'h3, 32'h0, 1'b0);
    check("tx_valid_flushed", 32'(tx_valid_o), 32'd0);
    access("ctl_run", 1'b1, 4'd0, 32'h2, 32'h0, 1'b0);
    access("irq_stat_clean", 1'b0, 4'd7, 32'h0, 32'h0, 1'b0);
    access("irq_en_ovf", 1'b1, 4'd6, 32'h8, 32'h0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      access($sformatf("tx_push%0d", i), 1'b1, 4'd2, 32'h10 + 32'(i), 32'h0, 1'b0);
    end
    access("status_full", 1'b0, 4'd4, 32'h0, 32'h0010_0024, 1'b0);
    check("tx_head", 32'(tx_data_o), 32'h010);
    resp_ready_i = 1'b0;
    drive_req("tx_ovf", 1'b1, 4'd2, 32'hEE, 32'h0, 1'b1);
    check("irq_lag", 32'(irq_o), 32'd0);
    tick();
    check("irq_set", 32'(irq_o), 32'd1);
    wait_resp(1'b0);
    access("irq_stat_ovf", 1'b0, 4'd7, 32'h0, 32'h08, 1'b0);
    access("irq_w1c_ovf", 1'b1, 4'd7, 32'h08, 32'h0, 1'b0);
    check("irq_cleared", 32'(irq_o), 32'd0);
    access("irq_stat_zero", 1'b0, 4'd7, 32'h0, 32'h0, 1'b0);

    // RX pop and underflow
    rx_valid_i = 1'b1;
    rx_data_i  = 8'h5C;
    tick();
    rx_valid_i = 1'b0;
    access("rx_5c", 1'b0, 4'd3, 32'h0, 32'h5C, 1'b0);
    access("rx_udf", 1'b0, 4'd3, 32'h0, 32'h0, 1'b1);
    access("irq_stat_rx", 1'b0, 4'd7, 32'h0, 32'h12, 1'b0);

    // Response held stable under back-pressure
    rx_valid_i = 1'b1;
    rx_data_i  = 8'h77;
    tick();
    rx_valid_i   = 1'b0;
    resp_ready_i = 1'b0;
    drive_req("rx_stall", 1'b0, 4'd3, 32'h0, 32'h77, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check($sformatf("stall_valid%0d", i), 32'(resp_valid_o), 32'd1);
      check($sformatf("stall_rdata%0d", i), resp_rdata_o, 32'h77);
      check($sformatf("stall_ready%0d", i), 32'(req_ready_o), 32'd0);
    end
    @(posedge clk_i);
    #1;
    wait_resp(1'b0);

    // Drain TX in order, tx_empty edge and NACK interrupts
    access("irq_w1c_all", 1'b1, 4'd7, 32'h1F, 32'h0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("tx_pop%0d", i), 32'(tx_data_o), 32'h10 + 32'(i));
      tx_ready_i = 1'b1;
      tick();
    end
    tx_ready_i = 1'b0;
    check("tx_drained", 32'(tx_valid_o), 32'd0);
    byte_done_i = 1'b1;
    rx_ack_i    = 1'b1;
    tick();
    byte_done_i = 1'b0;
    rx_ack_i    = 1'b0;
    access("irq_stat_empty_nack", 1'b0, 4'd7, 32'h0, 32'h05, 1'b0);

    // RX push in the same cycle as the W1C of rx_avail keeps the bit set
    rx_valid_i = 1'b1;
    rx_data_i  = 8'h33;
    drive_req("irq_w1c_race", 1'b1, 4'd7, 32'h07, 32'h0, 1'b0);
    rx_valid_i = 1'b0;
    wait_resp(1'b1);
    access("irq_stat_race", 1'b0, 4'd7, 32'h0, 32'h02, 1'b0);

    // Soft reset flushes FIFOs and IRQ_STAT but keeps registers
    rx_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rx_data_i = 8'h41 + 8'(i);
      tick();
    end
    rx_valid_i = 1'b0;
    access("status_rx4", 1'b0, 4'd4, 32'h0, 32'h0000_0410, 1'b0);
    access("cmd_stop", 1'b1, 4'd8, 32'h4, 32'h0, 1'b0);
    access("ctl_soft_rst", 1'b1, 4'd0, 32'h1, 32'h0, 1'b0);
    access("status_flushed", 1'b0, 4'd4, 32'h0, 32'h0000_0030, 1'b0);
    access("irq_stat_flushed", 1'b0, 4'd7, 32'h0, 32'h0, 1'b0);
    access("prescale_kept", 1'b0, 4'd1, 32'h0, 32'h1234, 1'b0);
    access("cmd_kept", 1'b0, 4'd8, 32'h0, 32'h4, 1'b0);
    access("irq_en_kept", 1'b0, 4'd6, 32'h0, 32'h08, 1'b0);

    // Asynchronous reset while a response is pending
    access("ctl_run2", 1'b1, 4'd0, 32'h2, 32'h0, 1'b0);
    resp_ready_i = 1'b0;
    drive_req("pre_arst", 1'b0, 4'd1, 32'h0, 32'h1234, 1'b0);
    check("arst_pending", 32'(resp_valid_o), 32'd1);
    #2;
    arstn_i = 1'b0;
    #1;
    check_rst("arst");
    exp_q.delete();
    name_q.delete();
    resp_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    arstn_i = 1'b1;
    tick();
    access("ctl_after_arst", 1'b0, 4'd0, 32'h0, 32'h1, 1'b0);
    access("pre_after_arst", 1'b0, 4'd1, 32'h0, 32'h0, 1'b0);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
